// File: rtl/mash_dsm_multi_if.sv
// Sample/strobe bundle for the multi-channel MASH modulator.
// Ports: en, dither_enable, in_valid, in_data (to modulator); out_valid, out_data (from modulator).
interface mash_dsm_multi_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16,
    parameter int OUT_BW   = 4
);
    logic                         en;
    logic                         dither_enable;
    logic                         in_valid;
    logic [CHANNELS*WIDTH-1:0]    in_data;
    logic                         out_valid;
    logic [CHANNELS*OUT_BW-1:0]   out_data;

    modport master (
        output en,
        output dither_enable,
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  en,
        input  dither_enable,
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mash_dsm_multi.sv
// Multi-channel MASH 1/1-1/1-1-1 delta-sigma modulator with shared LFSR LSB dither.
// Ports: aclk, rst (sync, active-high), bus (slave: en, dither_enable, in_valid, in_data -> out_valid, out_data).
module mash_dsm_multi #(
    parameter int ORDER    = 2,
    parameter int WIDTH    = 16,
    parameter int OUT_BW   = 4,
    parameter int CHANNELS = 2
) (
    input  logic            aclk,
    input  logic            rst,
    mash_dsm_multi_if.slave bus
);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0]                lfsr;
    logic                       lfsr_fb;

    logic [WIDTH-1:0]           x    [CHANNELS];
    logic [WIDTH-1:0]           acc1 [CHANNELS];
    logic [WIDTH-1:0]           acc2 [CHANNELS];
    logic [WIDTH-1:0]           acc3 [CHANNELS];

    logic [WIDTH:0]             s1   [CHANNELS];
    logic [WIDTH:0]             s2   [CHANNELS];
    logic [WIDTH:0]             s3   [CHANNELS];
    logic [3:0]                 y    [CHANNELS];

    logic [CHANNELS-1:0]        dith;
    logic [CHANNELS-1:0]        c1;
    logic [CHANNELS-1:0]        c2;
    logic [CHANNELS-1:0]        c3;
    logic [CHANNELS-1:0]        c2d;
    logic [CHANNELS-1:0]        c3d;
    logic [CHANNELS-1:0]        c3dd;

    logic [CHANNELS*OUT_BW-1:0] out_next;
    logic [CHANNELS*OUT_BW-1:0] out_q;
    logic                       out_valid_q;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_comb begin
        dith     = '0;
        c1       = '0;
        c2       = '0;
        c3       = '0;
        out_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            s1[k] = '0;
            s2[k] = '0;
            s3[k] = '0;
            y[k]  = '0;
        end
        for (int k = 0; k < CHANNELS; k++) begin
            dith[k] = bus.dither_enable & lfsr[k];
            // acc + x + 1 tops out at 2^(WIDTH+1)-1, so one extra bit holds it.
            s1[k] = {1'b0, acc1[k]} + {1'b0, x[k]} + (WIDTH+1)'(dith[k]);
            c1[k] = s1[k][WIDTH];
            if (ORDER >= 2) begin
                s2[k] = {1'b0, acc2[k]} + {1'b0, s1[k][WIDTH-1:0]};
                c2[k] = s2[k][WIDTH];
            end
            if (ORDER >= 3) begin
                s3[k] = {1'b0, acc3[k]} + {1'b0, s2[k][WIDTH-1:0]};
                c3[k] = s3[k][WIDTH];
            end
            // 4-bit two's complement covers -3..4; wrap in the
            // intermediate terms cancels out in the final sum.
            y[k] = {3'b000, c1[k]};
            if (ORDER >= 2) begin
                y[k] = y[k] + {3'b000, c2[k]} - {3'b000, c2d[k]};
            end
            if (ORDER >= 3) begin
                y[k] = y[k] + {3'b000, c3[k]}
                     - {2'b00, c3d[k], 1'b0}
                     + {3'b000, c3dd[k]};
            end
            out_next[k*OUT_BW +: OUT_BW] = OUT_BW'($signed(y[k]));
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            lfsr        <= LFSR_SEED;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            c2d         <= '0;
            c3d         <= '0;
            c3dd        <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                x[k]    <= '0;
                acc1[k] <= '0;
                acc2[k] <= '0;
                acc3[k] <= '0;
            end
        end else begin
            out_valid_q <= bus.en;
            // Input load is independent of en; an en on the same edge
            // still sees the previous x.
            if (bus.in_valid) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    x[k] <= bus.in_data[k*WIDTH +: WIDTH];
                end
            end
            if (bus.en) begin
                lfsr  <= {lfsr_fb, lfsr[15:1]};
                out_q <= out_next;
                c2d   <= c2;
                c3d   <= c3;
                c3dd  <= c3d;
                for (int k = 0; k < CHANNELS; k++) begin
                    acc1[k] <= s1[k][WIDTH-1:0];
                    acc2[k] <= s2[k][WIDTH-1:0];
                    acc3[k] <= s3[k][WIDTH-1:0];
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
endmodule

// File: tb/tb_mash_dsm_multi.sv
// Scoreboard bench for mash_dsm_multi: ORDER 1, 2 and 3 instances driven in lockstep
// from one stimulus stream, checked against an arithmetic reference model.
module tb_mash_dsm_multi;
    localparam int W  = 16;
    localparam int CH = 2;
    localparam int OB = 4;
    localparam int M  = 65536;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    always #5 aclk = ~aclk;

    mash_dsm_multi_if #(.CHANNELS(CH), .WIDTH(W), .OUT_BW(OB)) b1 ();
    mash_dsm_multi_if #(.CHANNELS(CH), .WIDTH(W), .OUT_BW(OB)) b2 ();
    mash_dsm_multi_if #(.CHANNELS(CH), .WIDTH(W), .OUT_BW(OB)) b3 ();

    mash_dsm_multi #(.ORDER(1), .WIDTH(W), .OUT_BW(OB), .CHANNELS(CH)) u1 (
        .aclk(aclk), .rst(rst), .bus(b1.slave));
    mash_dsm_multi #(.ORDER(2), .WIDTH(W), .OUT_BW(OB), .CHANNELS(CH)) u2 (
        .aclk(aclk), .rst(rst), .bus(b2.slave));
    mash_dsm_multi #(.ORDER(3), .WIDTH(W), .OUT_BW(OB), .CHANNELS(CH)) u3 (
        .aclk(aclk), .rst(rst), .bus(b3.slave));

    typedef struct {
        logic             valid;
        logic [CH*OB-1:0] data;
    } exp_t;

    exp_t sq[3][$];

    logic             ov [3];
    logic [CH*OB-1:0] od [3];
    assign ov[0] = b1.out_valid;
    assign ov[1] = b2.out_valid;
    assign ov[2] = b3.out_valid;
    assign od[0] = b1.out_data;
    assign od[1] = b2.out_data;
    assign od[2] = b3.out_data;

    int vectors     = 0;
    int miscompares = 0;
    int sum_ch[CH];
    int diffcnt     = 0;

    // Reference model state: plain integers.
    int          mx [CH];
    int          macc [3][CH][3];
    int          mc2d [3][CH];
    int          mc3d [3][CH];
    int          mc3dd[3][CH];
    int          mout [3][CH];
    logic [15:0] mlfsr;
    bit          mvalid;

    function automatic int s4(logic [3:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit e, bit dth, bit iv, int d0, int d1);
        int s, c[3], d, y, fb;
        if (r) begin
            for (int o = 0; o < 3; o++)
                for (int ch = 0; ch < CH; ch++) begin
                    for (int st = 0; st < 3; st++) macc[o][ch][st] = 0;
                    mc2d[o][ch] = 0; mc3d[o][ch] = 0; mc3dd[o][ch] = 0;
                    mout[o][ch] = 0;
                end
            for (int ch = 0; ch < CH; ch++) mx[ch] = 0;
            mlfsr  = 16'hACE1;
            mvalid = 0;
            return;
        end
        mvalid = e;
        if (e) begin
            for (int o = 0; o < 3; o++)
                for (int ch = 0; ch < CH; ch++) begin
                    d = dth ? int'(mlfsr[ch]) : 0;
                    s = macc[o][ch][0] + mx[ch] + d;
                    c[0] = s / M; macc[o][ch][0] = s % M;
                    s = macc[o][ch][1] + macc[o][ch][0];
                    c[1] = s / M; macc[o][ch][1] = s % M;
                    s = macc[o][ch][2] + macc[o][ch][1];
                    c[2] = s / M; macc[o][ch][2] = s % M;
                    y = c[0];
                    if (o >= 1) y += c[1] - mc2d[o][ch];
                    if (o >= 2) y += c[2] - 2 * mc3d[o][ch] + mc3dd[o][ch];
                    mc3dd[o][ch] = mc3d[o][ch];
                    mc3d[o][ch]  = c[2];
                    mc2d[o][ch]  = c[1];
                    mout[o][ch]  = y;
                end
            // feedback from taps at exponents 16, 14, 13, 11
            fb = mlfsr[16-16] ^ mlfsr[16-14] ^ mlfsr[16-13] ^ mlfsr[16-11];
            mlfsr = {fb[0], mlfsr[15:1]};
        end
        if (iv) begin
            mx[0] = d0;
            mx[1] = d1;
        end
    endtask

    task automatic tick(bit r, bit e, bit dth, bit iv, int d0, int d1);
        logic [CH*W-1:0] din;
        din = {d1[15:0], d0[15:0]};
        @(negedge aclk);
        rst = r;
        b1.en = e; b1.dither_enable = dth; b1.in_valid = iv; b1.in_data = din;
        b2.en = e; b2.dither_enable = dth; b2.in_valid = iv; b2.in_data = din;
        b3.en = e; b3.dither_enable = dth; b3.in_valid = iv; b3.in_data = din;
        model_step(r, e, dth, iv, d0, d1);
        @(posedge aclk);
        for (int o = 0; o < 3; o++) begin
            exp_t ex;
            ex.valid = mvalid;
            ex.data  = '0;
            for (int ch = 0; ch < CH; ch++)
                ex.data[ch*OB +: OB] = 4'(mout[o][ch]);
            sq[o].push_back(ex);
        end
    endtask

    // Monitor: pops one expectation per instance whenever one is pending.
    initial begin
        int lo[3];
        int hi[3];
        exp_t ex;
        logic [3:0] cv;
        int v, v0;
        lo = '{0, -1, -3};
        hi = '{1, 2, 4};
        forever begin
            @(negedge aclk);
            for (int o = 0; o < 3; o++) begin
                if (sq[o].size() > 0) begin
                    ex = sq[o].pop_front();
                    vectors++;
                    if (ov[o] !== ex.valid || od[o] !== ex.data) begin
                        miscompares++;
                        $display("FAIL ord%0d_out: got v=%b d=%h expected v=%b d=%h",
                                 o + 1, ov[o], od[o], ex.valid, ex.data);
                    end
                    for (int ch = 0; ch < CH; ch++) begin
                        cv = od[o][ch*OB +: OB];
                        v  = s4(cv);
                        vectors++;
                        if (v < lo[o] || v > hi[o]) begin
                            miscompares++;
                            $display("FAIL ord%0d_range ch%0d: got %0d expected %0d..%0d",
                                     o + 1, ch, v, lo[o], hi[o]);
                        end
                        if (o == 2 && ov[o] === 1'b1) sum_ch[ch] += v;
                        if (ch == 0) v0 = v;
                        else if (o == 2 && ov[o] === 1'b1 && v != v0) diffcnt++;
                    end
                end
            end
        end
    end

    initial begin
        int p2[4];
        int en_pat[4];
        p2     = '{0, 1, 1, 0};
        en_pat = '{1, 0, 0, 1};
        sum_ch = '{0, 0};
        b1.en = 0; b1.dither_enable = 0; b1.in_valid = 0; b1.in_data = '0;
        b2.en = 0; b2.dither_enable = 0; b2.in_valid = 0; b2.in_data = '0;
        b3.en = 0; b3.dither_enable = 0; b3.in_valid = 0; b3.in_data = '0;

        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        #1;
        chk("reset_data", int'(b3.out_data), 0);
        chk("reset_valid", int'(b3.out_valid), 0);

        // Order-1 ch0 at 0x4000 and order-2 ch1 at 0x8000 from a fresh start.
        tick(0, 0, 0, 1, 'h4000, 'h8000);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            #1;
            chk("o1_pattern", s4(b1.out_data[3:0]), (i % 4 == 3) ? 1 : 0);
            chk("o2_pattern", s4(b2.out_data[7:4]), p2[i % 4]);
        end

        // en gaps: out_valid follows en one cycle later.
        for (int i = 0; i < 4; i++) begin
            tick(0, en_pat[i][0], 0, 0, 0, 0);
            #1;
            chk("valid_follow", int'(b2.out_valid), en_pat[i]);
        end

        // Load coincident with en: this edge still uses the old x.
        tick(0, 1, 0, 1, 'hC000, 'h8000);
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 0, 0, 0);

        // Randomised stream, then a single-cycle reset mid-stream.
        for (int i = 0; i < 300; i++)
            tick(0, ($urandom % 4) != 0, $urandom % 2, ($urandom % 5) == 0,
                 $urandom_range(0, 65535), $urandom_range(0, 65535));
        tick(1, 1, 1, 1, 'h1234, 'h5678);
        #1;
        chk("midreset_data1", int'(b1.out_data), 0);
        chk("midreset_data3", int'(b3.out_data), 0);
        chk("midreset_valid", int'(b3.out_valid), 0);
        tick(0, 0, 1, 1, 'h3333, 'hABCD);
        for (int i = 0; i < 40; i++) tick(0, 1, 1, 0, 0, 0);

        // Boundaries: zero input and full-scale input, dither off then on.
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 'hFFFF);
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            #1;
            chk("zero_in", s4(b3.out_data[3:0]), 0);
        end
        for (int i = 0; i < 40; i++) tick(0, 1, 1, 0, 0, 0);

        // Long dithered order-3 run.
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 'h1000, 'hF000);
        sum_ch  = '{0, 0};
        diffcnt = 0;
        for (int i = 0; i < 65536; i++) tick(0, 1, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        @(negedge aclk);
        #1;
        vectors++;
        if (sum_ch[0] < 4096 - 8 || sum_ch[0] > 4096 + 8) begin
            miscompares++;
            $display("FAIL sum_ch0: got %0d expected 4096+-8", sum_ch[0]);
        end
        vectors++;
        if (sum_ch[1] < 61440 - 8 || sum_ch[1] > 61440 + 8) begin
            miscompares++;
            $display("FAIL sum_ch1: got %0d expected 61440+-8", sum_ch[1]);
        end
        chk("streams_distinct", int'(diffcnt > 0), 1);
        for (int o = 0; o < 3; o++) chk("queue_drained", sq[o].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
